prog_clock_divider: RTL

Parametrised, runtime-programmable multi-channel clock divider. It generates NUM_CH independent 50%-duty divided clocks, each with a single-cycle tick strobe. Every channel has its own enable, a shared synchronous phase-align clear, and a divisor that can be reprogrammed without glitches. It sits beside the system clock input and feeds slow-rate logic (display scan, seconds counters, debouncers) in place of fixed-ratio dividers.

---
 rtl/prog_clock_divider_pkg.sv | 8 +
 rtl/div_channel.sv | 53 +++++
 rtl/prog_clock_divider.sv | 31 +++
 3 files changed

// File: rtl/prog_clock_divider_pkg.sv
// prog_clock_divider_pkg: shared constants for the programmable clock divider.
package prog_clock_divider_pkg;
   localparam int DEF_HALF_1HZ   = 20_000_000;
   localparam int DEF_HALF_100HZ = 200_000;
   localparam int CNT_W_DEF      = 25;
   localparam int CH_IDX_W       = 3;
   localparam int MAX_CH         = 8;
endpackage

// File: rtl/div_channel.sv
// div_channel: one 50%-duty divider channel with glitch-free half-period reprogramming.
module div_channel import prog_clock_divider_pkg::*; #(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DEF_HALF = DEF_HALF_1HZ
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] half_i,
   output logic             clk_out_o,
   output logic             tick_o,
   output logic             busy_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, pend_half_q, pend_half_d, h;
   logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, term, apply;

   // >= keeps the counter bounded if a disabled-channel update shrinks the half below cnt
   always_comb begin
      h           = (half_q == '0) ? CNT_W'(1) : half_q;
      term        = en_i && (cnt_q >= h - 1'b1);
      apply       = pend_q && (clr_i || !en_i || term);
      cnt_d       = (clr_i || term) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
      clk_d       = !clr_i && (term ? !clk_q : clk_q);
      tick_d      = !clr_i && term && !clk_q;
      half_d      = (clr_i && we_i) ? half_i : apply ? pend_half_q : half_q;
      pend_half_d = we_i ? half_i : pend_half_q;
      pend_d      = !clr_i && (we_i || (pend_q && !apply));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         half_q      <= CNT_W'(DEF_HALF);
         pend_half_q <= '0;
         pend_q      <= 1'b0;
         clk_q       <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         half_q      <= half_d;
         pend_half_q <= pend_half_d;
         pend_q      <= pend_d;
         clk_q       <= clk_d;
         tick_q      <= tick_d;
      end
   end

   assign clk_out_o = clk_q;
   assign tick_o    = tick_q;
   assign busy_o    = pend_q;
endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: NUM_CH runtime-programmable 50%-duty clock dividers with tick strobes.
module prog_clock_divider import prog_clock_divider_pkg::*; #(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DEF_HALF = DEF_HALF_1HZ
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_CH-1:0]   en,
   input  logic                clr,
   input  logic                cfg_we,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [CNT_W-1:0]    cfg_half,
   output logic [NUM_CH-1:0]   clk_out,
   output logic [NUM_CH-1:0]   tick,
   output logic [NUM_CH-1:0]   busy
);
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      div_channel #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .en_i      (en[g]),
         .clr_i     (clr),
         .we_i      (cfg_we && (cfg_ch == CH_IDX_W'(g))),
         .half_i    (cfg_half),
         .clk_out_o (clk_out[g]),
         .tick_o    (tick[g]),
         .busy_o    (busy[g])
      );
   end
endmodule
